// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon Says controller and its player-entry receiver.
package simon_pkg;

  localparam int IDX_W = 4;

  // Controller sequencing states (owned by the simon controller).
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SHOW,
    ST_EVAL,
    ST_FAIL,
    ST_WIN
  } state_t;

  typedef enum logic [1:0] {
    E_IDLE,
    E_WAIT_PRESS,
    E_WAIT_RELEASE,
    E_RESULT
  } entry_state_t;

  function automatic logic is_onehot16(input logic [15:0] v);
    return (v != '0) && ((v & (v - 16'd1)) == '0);
  endfunction

  function automatic logic [IDX_W-1:0] enc16(input logic [15:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/simon_entry_if.sv
// Controller <-> player-entry receiver bundle: raw buttons, arm/expected sequence, results.
interface simon_entry_if #(
  parameter int MAX_LEN = 4
);

  logic [15:0]          in;
  logic                 arm;
  logic [4*MAX_LEN-1:0] exp_seq;
  logic [2:0]           exp_len;
  logic                 busy;
  logic                 done;
  logic                 pass;
  logic                 fail;
  logic                 timeout;
  logic [4*MAX_LEN-1:0] entered;
  logic [2:0]           count;

  modport master (
    output in, arm, exp_seq, exp_len,
    input  busy, done, pass, fail, timeout, entered, count
  );

  modport slave (
    input  in, arm, exp_seq, exp_len,
    output busy, done, pass, fail, timeout, entered, count
  );

endinterface

// File: rtl/simon_sync.sv
// Two-flop synchronizer for the 16 raw buttons plus the previous-sample register,
// producing the synchronized vector and a press strobe (any-button-down after all-up).
module simon_sync (
  input  logic        clk,
  input  logic        nrst,
  input  logic [15:0] i_in,
  output logic [15:0] o_s,
  output logic        o_press
);

  logic [15:0] r_meta;
  logic [15:0] r_s;
  logic [15:0] r_s_prev;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_meta   <= '0;
      r_s      <= '0;
      r_s_prev <= '0;
    end else begin
      r_meta   <= i_in;
      r_s      <= r_meta;
      r_s_prev <= r_s;
    end
  end

  assign o_s     = r_s;
  assign o_press = (r_s != '0) && (r_s_prev == '0);

endmodule

// File: rtl/simon_entry.sv
// Player-entry receiver: once armed, captures button presses, checks each against the
// expected nibble sequence and reports pass / fail / timeout back to the controller.
module simon_entry #(
  parameter int MAX_LEN = 4,
  parameter int TIMEOUT = 2000
) (
  input logic          clk,
  input logic          nrst,
  simon_entry_if.slave bus
);

  import simon_pkg::*;

  localparam int             TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]  T_LAST = TW'(TIMEOUT - 1);

  entry_state_t          r_state;
  entry_state_t          w_state_nxt;

  logic [4*MAX_LEN-1:0]  r_exp_seq;
  logic [2:0]            r_exp_len;
  logic [2:0]            r_count;
  logic [4*MAX_LEN-1:0]  r_entered;
  logic [TW-1:0]         r_timer;
  logic                  r_pass;
  logic                  r_fail;
  logic                  r_timeout;

  logic [15:0]           w_s;
  logic                  w_press;
  logic                  w_onehot;
  logic [IDX_W-1:0]      w_idx;
  logic [IDX_W-1:0]      w_exp_nib;
  logic                  w_len_ok;
  logic                  w_expired;

  logic                  w_accept;
  logic                  w_store;
  logic                  w_timer_inc;
  logic                  w_timer_clr;
  logic                  w_set_pass;
  logic                  w_set_fail;
  logic                  w_set_to;

  simon_sync u_sync (
    .clk     (clk),
    .nrst    (nrst),
    .i_in    (bus.in),
    .o_s     (w_s),
    .o_press (w_press)
  );

  assign w_onehot  = is_onehot16(w_s);
  assign w_idx     = enc16(w_s);
  assign w_len_ok  = (bus.exp_len != '0) && (int'(bus.exp_len) <= MAX_LEN);
  assign w_expired = (r_timer == T_LAST);

  always_comb begin
    w_exp_nib = '0;
    for (int unsigned k = 0; k < MAX_LEN; k++) begin
      if (r_count == 3'(k)) w_exp_nib = r_exp_seq[4*k +: 4];
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst) r_state <= E_IDLE;
    else       r_state <= w_state_nxt;
  end

  // A press event is checked before timer expiry so a press on the last cycle still counts.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_store     = 1'b0;
    w_timer_inc = 1'b0;
    w_timer_clr = 1'b0;
    w_set_pass  = 1'b0;
    w_set_fail  = 1'b0;
    w_set_to    = 1'b0;
    unique case (r_state)
      E_IDLE: begin
        if (bus.arm && w_len_ok) begin
          w_accept    = 1'b1;
          w_state_nxt = E_WAIT_PRESS;
        end
      end
      E_WAIT_PRESS: begin
        w_timer_inc = 1'b1;
        if (w_press) begin
          if (!w_onehot) begin
            w_set_fail  = 1'b1;
            w_state_nxt = E_RESULT;
          end else begin
            w_store = 1'b1;
            if (w_idx != w_exp_nib) begin
              w_set_fail  = 1'b1;
              w_state_nxt = E_RESULT;
            end else if ((r_count + 3'd1) == r_exp_len) begin
              w_set_pass  = 1'b1;
              w_state_nxt = E_RESULT;
            end else begin
              w_state_nxt = E_WAIT_RELEASE;
            end
          end
        end else if (w_expired) begin
          w_set_fail  = 1'b1;
          w_set_to    = 1'b1;
          w_state_nxt = E_RESULT;
        end
      end
      E_WAIT_RELEASE: begin
        if (w_s == '0) begin
          w_timer_clr = 1'b1;
          w_state_nxt = E_WAIT_PRESS;
        end
      end
      E_RESULT: begin
        w_state_nxt = E_IDLE;
      end
      default: begin
        w_state_nxt = E_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      r_exp_seq <= '0;
      r_exp_len <= '0;
      r_count   <= '0;
      r_entered <= '0;
      r_timer   <= '0;
      r_pass    <= 1'b0;
      r_fail    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      if (w_accept) begin
        r_exp_seq <= bus.exp_seq;
        r_exp_len <= bus.exp_len;
        r_count   <= '0;
        r_entered <= '0;
        r_pass    <= 1'b0;
        r_fail    <= 1'b0;
        r_timeout <= 1'b0;
      end

      if (w_accept || w_timer_clr) begin
        r_timer <= '0;
      end else if (w_timer_inc && !w_expired) begin
        r_timer <= r_timer + 1'b1;
      end

      if (w_store) begin
        r_count <= r_count + 3'd1;
        for (int unsigned k = 0; k < MAX_LEN; k++) begin
          if (r_count == 3'(k)) r_entered[4*k +: 4] <= w_idx;
        end
      end

      if (w_set_pass) r_pass    <= 1'b1;
      if (w_set_fail) r_fail    <= 1'b1;
      if (w_set_to)   r_timeout <= 1'b1;
    end
  end

  assign bus.busy    = (r_state == E_WAIT_PRESS) || (r_state == E_WAIT_RELEASE);
  assign bus.done    = (r_state == E_RESULT);
  assign bus.pass    = r_pass;
  assign bus.fail    = r_fail;
  assign bus.timeout = r_timeout;
  assign bus.entered = r_entered;
  assign bus.count   = r_count;

endmodule

// File: tb/tb_simon_entry.sv
// Self-checking bench for simon_entry: reset, table vectors, timing corners and
// randomized entries checked against a sequence-level reference model.
module tb_simon_entry;

  localparam int ML = 4;
  localparam int TO = 20;

  logic clk;
  logic nrst;

  simon_entry_if #(.MAX_LEN(ML)) ifc ();

  simon_entry #(.MAX_LEN(ML), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        pass;
    logic        fail;
    logic        to;
    logic [2:0]  count;
    logic [15:0] entered;
  } res_t;

  typedef struct {
    logic [15:0]      seq;
    logic [2:0]       len;
    int               np;
    logic [3:0][15:0] pr;
    res_t             exp;
  } vec_t;

  int unsigned n_total = 0;
  int unsigned n_pass  = 0;
  int unsigned done_cnt = 0;
  res_t        snap;
  logic        snap_busy;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  // Snapshot the held results in every cycle that done is high.
  always @(negedge clk) begin
    if (ifc.done === 1'b1) begin
      done_cnt++;
      snap      = '{pass: ifc.pass, fail: ifc.fail, to: ifc.timeout,
                    count: ifc.count, entered: ifc.entered};
      snap_busy = ifc.busy;
    end
  end

  // Reference: walk the press list using the game rules only.
  function automatic res_t model(input logic [15:0] seq, input logic [2:0] len,
                                 input logic [3:0][15:0] pr, input int np);
    res_t r;
    int   cnt;
    int   idx;
    r   = '0;
    cnt = 0;
    for (int i = 0; i < np; i++) begin
      if ($countones(pr[i]) != 1) begin
        r.fail = 1'b1;
        break;
      end
      idx = $clog2(pr[i]);
      r.entered[4*cnt +: 4] = idx[3:0];
      cnt++;
      if (idx[3:0] != seq[4*(cnt-1) +: 4]) begin
        r.fail = 1'b1;
        break;
      end
      if (cnt == int'(len)) begin
        r.pass = 1'b1;
        break;
      end
    end
    if (!r.pass && !r.fail) begin
      r.fail = 1'b1;
      r.to   = 1'b1;
    end
    r.count = 3'(cnt);
    return r;
  endfunction

  function automatic vec_t mk(input logic [15:0] seq, input logic [2:0] len, input int np,
                              input logic [3:0][15:0] pr, input res_t e);
    vec_t v;
    v.seq = seq; v.len = len; v.np = np; v.pr = pr; v.exp = e;
    return v;
  endfunction

  task automatic arm(input logic [15:0] seq, input logic [2:0] len);
    @(negedge clk);
    ifc.arm     = 1'b1;
    ifc.exp_seq = seq;
    ifc.exp_len = len;
    @(posedge clk);
    #1 ifc.arm = 1'b0;
  endtask

  task automatic press(input logic [15:0] v, input int hold, input int gap);
    @(negedge clk);
    ifc.in = v;
    repeat (hold) @(negedge clk);
    ifc.in = '0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic wait_done(input int unsigned d0, output int unsigned nd);
    for (int c = 0; c < 80; c++) begin
      if (done_cnt != d0) break;
      @(posedge clk);
    end
    repeat (3) @(posedge clk);
    nd = done_cnt - d0;
  endtask

  task automatic cmp(input string tag, input int unsigned nd, input res_t e);
    check($sformatf("%s.done_pulses", tag), nd, 1);
    check($sformatf("%s.pass", tag), snap.pass, e.pass);
    check($sformatf("%s.fail", tag), snap.fail, e.fail);
    check($sformatf("%s.timeout", tag), snap.to, e.to);
    check($sformatf("%s.count", tag), snap.count, e.count);
    check($sformatf("%s.entered", tag), snap.entered, e.entered);
    check($sformatf("%s.busy_at_done", tag), snap_busy, 1'b0);
  endtask

  task automatic run_entry(input logic [15:0] seq, input logic [2:0] len,
                           input logic [3:0][15:0] pr, input int np, input bit rnd,
                           output int unsigned nd);
    int unsigned d0;
    int h, g;
    d0 = done_cnt;
    arm(seq, len);
    for (int i = 0; i < np; i++) begin
      h = rnd ? int'($urandom_range(4, 1)) : 2;
      g = rnd ? int'($urandom_range(6, 1)) : 2;
      press(pr[i], h, g);
    end
    wait_done(d0, nd);
  endtask

  vec_t vecs[8];

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned nd, d0;
    int          n;
    logic [15:0] seq;
    logic [2:0]  len;
    logic [3:0][15:0] pr;
    int          np;
    logic [15:0] v;
    res_t        e;

    vecs[0] = mk(16'h0951, 3'd3, 3, {16'h0000, 16'h0200, 16'h0020, 16'h0002}, {1'b1, 1'b0, 1'b0, 3'd3, 16'h0951});
    vecs[1] = mk(16'h0951, 3'd3, 2, {16'h0000, 16'h0000, 16'h0010, 16'h0002}, {1'b0, 1'b1, 1'b0, 3'd2, 16'h0041});
    vecs[2] = mk(16'h0951, 3'd3, 1, {16'h0000, 16'h0000, 16'h0000, 16'h0006}, {1'b0, 1'b1, 1'b0, 3'd0, 16'h0000});
    vecs[3] = mk(16'h0951, 3'd3, 1, {16'h0000, 16'h0000, 16'h0000, 16'h0002}, {1'b0, 1'b1, 1'b1, 3'd1, 16'h0001});
    vecs[4] = mk(16'h000F, 3'd1, 1, {16'h0000, 16'h0000, 16'h0000, 16'h8000}, {1'b1, 1'b0, 1'b0, 3'd1, 16'h000F});
    vecs[5] = mk(16'hFEDC, 3'd4, 4, {16'h8000, 16'h4000, 16'h2000, 16'h1000}, {1'b1, 1'b0, 1'b0, 3'd4, 16'hFEDC});
    vecs[6] = mk(16'h3210, 3'd4, 4, {16'h0009, 16'h0004, 16'h0002, 16'h0001}, {1'b0, 1'b1, 1'b0, 3'd3, 16'h0210});
    vecs[7] = mk(16'h0951, 3'd3, 0, {16'h0000, 16'h0000, 16'h0000, 16'h0000}, {1'b0, 1'b1, 1'b1, 3'd0, 16'h0000});

    ifc.in = 16'hFFFF; ifc.arm = 1'b0; ifc.exp_seq = '0; ifc.exp_len = '0;
    nrst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst.busy", ifc.busy, 1'b0);
    check("rst.done", ifc.done, 1'b0);
    check("rst.pass", ifc.pass, 1'b0);
    check("rst.fail", ifc.fail, 1'b0);
    check("rst.timeout", ifc.timeout, 1'b0);
    check("rst.entered", ifc.entered, 16'h0);
    check("rst.count", ifc.count, 3'd0);
    ifc.in = '0;
    repeat (3) @(negedge clk);
    nrst = 1'b1;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_entry(vecs[i].seq, vecs[i].len, vecs[i].pr, vecs[i].np, 1'b0, nd);
      cmp($sformatf("vec%0d", i), nd, vecs[i].exp);
    end

    // Timeout latency, measured from the cycle arm is accepted.
    d0 = done_cnt;
    arm(16'h0951, 3'd3);
    n = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      n++;
      if (n == 1) check("to_lat.busy_rise", ifc.busy, 1'b1);
      if (ifc.done === 1'b1) break;
    end
    check("to_lat.cycles", n, TO + 1);
    check("to_lat.fail", ifc.fail, 1'b1);
    check("to_lat.timeout", ifc.timeout, 1'b1);
    check("to_lat.busy_fall", ifc.busy, 1'b0);
    wait_done(d0, nd);
    check("to_lat.done_pulses", nd, 1);

    // Press landing on the final timer cycle beats expiry.
    d0 = done_cnt;
    arm(16'h0005, 3'd1);
    repeat (TO - 2) @(negedge clk);
    ifc.in = 16'h0020;
    repeat (3) @(negedge clk);
    ifc.in = '0;
    wait_done(d0, nd);
    cmp("tie_press", nd, {1'b1, 1'b0, 1'b0, 3'd1, 16'h0005});

    // One cycle later the timer has already expired.
    d0 = done_cnt;
    arm(16'h0005, 3'd1);
    repeat (TO - 1) @(negedge clk);
    ifc.in = 16'h0020;
    repeat (3) @(negedge clk);
    ifc.in = '0;
    wait_done(d0, nd);
    cmp("late_press", nd, {1'b0, 1'b1, 1'b1, 3'd0, 16'h0000});
    repeat (4) @(negedge clk);

    // Button held at arm is ignored until released.
    d0 = done_cnt;
    ifc.in = 16'h0002;
    repeat (4) @(negedge clk);
    arm(16'h0951, 3'd3);
    repeat (5) @(negedge clk);
    check("held.count", ifc.count, 3'd0);
    check("held.busy", ifc.busy, 1'b1);
    ifc.in = '0;
    repeat (2) @(negedge clk);
    press(16'h0002, 2, 2);
    press(16'h0020, 2, 2);
    press(16'h0200, 2, 2);
    wait_done(d0, nd);
    cmp("held", nd, {1'b1, 1'b0, 1'b0, 3'd3, 16'h0951});

    // Second arm while busy must not reload the sequence.
    d0 = done_cnt;
    arm(16'h0951, 3'd3);
    press(16'h0002, 2, 1);
    arm(16'h0FFF, 3'd1);
    press(16'h0020, 2, 2);
    press(16'h0200, 2, 2);
    wait_done(d0, nd);
    cmp("rearm", nd, {1'b1, 1'b0, 1'b0, 3'd3, 16'h0951});

    // Out-of-range lengths are not accepted.
    d0 = done_cnt;
    arm(16'h0951, 3'd0);
    @(negedge clk);
    check("len0.busy", ifc.busy, 1'b0);
    arm(16'h0951, 3'd5);
    @(negedge clk);
    check("len5.busy", ifc.busy, 1'b0);
    repeat (TO + 5) @(negedge clk);
    check("badlen.no_done", done_cnt - d0, 0);

    // Reset mid-entry aborts without done.
    d0 = done_cnt;
    arm(16'h0951, 3'd3);
    press(16'h0002, 2, 2);
    check("midrst.count_before", ifc.count, 3'd1);
    nrst = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    check("midrst.count", ifc.count, 3'd0);
    check("midrst.busy", ifc.busy, 1'b0);
    check("midrst.entered", ifc.entered, 16'h0);
    repeat (TO + 10) @(negedge clk);
    check("midrst.no_done", done_cnt - d0, 0);

    // Randomized entries against the reference model.
    for (int t = 0; t < 30; t++) begin
      seq = 16'($urandom);
      len = 3'($urandom_range(ML, 1));
      np  = ($urandom_range(5, 0) == 0) ? int'($urandom_range(int'(len) - 1, 0)) : int'(len);
      pr  = '0;
      for (int i = 0; i < np; i++) begin
        case ($urandom_range(9, 0))
          0: begin
            v = 16'($urandom);
            if ($countones(v) < 2) v = v | 16'h8001;
          end
          1, 2: v = 16'(1) << $urandom_range(15, 0);
          default: v = 16'(1) << seq[4*i +: 4];
        endcase
        pr[i] = v;
      end
      e = model(seq, len, pr, np);
      run_entry(seq, len, pr, np, 1'b1, nd);
      cmp($sformatf("rnd%0d", t), nd, e);
      check($sformatf("rnd%0d.exclusive", t), snap.pass & snap.fail, 1'b0);
      repeat (2) @(negedge clk);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
